// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: Moore-style FSM sequencing a MIPS-like datapath
// (lw, sw, R-type, beq, addi, j) with a retired-instruction counter and an
// illegal-opcode pulse.
module multicycle_control_unit #(
  parameter int INSTR_W       = 32,
  parameter int CNT_W         = 16,
  parameter int JUMP_EN       = 1,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_en,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic [3:0]         state,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_instr_count;
  logic             r_illegal;
  logic             w_retire;
  logic             w_illegal_det;
  logic [5:0]       w_opcode;
  logic             w_mem_ready;
  logic             w_unused_instr_bits;

  // Raw (pre-reset-gating) output decode.
  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_iord;
  logic       w_ir_write;
  logic       w_pc_en;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_pc_src;

  assign w_opcode            = instr[INSTR_W-1 -: 6];
  assign w_unused_instr_bits = ^instr[INSTR_W-7:0];
  // Without a handshake the memory is treated as single-cycle.
  assign w_mem_ready         = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, retire detection and illegal-opcode detection.
  always_comb begin
    w_next_state  = r_state;
    w_retire      = 1'b0;
    w_illegal_det = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_mem_ready) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        case (w_opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J: begin
            if (JUMP_EN != 0) begin
              w_next_state = S_JUMP;
            end else begin
              w_next_state  = S_FETCH;
              w_illegal_det = 1'b1;
            end
          end
          default: begin
            w_next_state  = S_FETCH;
            w_illegal_det = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (w_opcode == OP_LW) begin
          w_next_state = S_MEMRD;
        end else begin
          w_next_state = S_MEMWR;
        end
      end
      S_MEMRD: begin
        if (w_mem_ready) begin
          w_next_state = S_MEMWB;
        end else begin
          w_next_state = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (w_mem_ready) begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end else begin
          w_next_state = S_MEMWR;
        end
      end
      S_EXEC:   w_next_state = S_ALUWB;
      S_ADDIEX: w_next_state = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  // Retired-instruction counter (wraps naturally) and one-cycle illegal pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_count <= {CNT_W{1'b0}};
      r_illegal     <= 1'b0;
    end else begin
      r_illegal <= w_illegal_det;
      if (w_retire) begin
        r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_instr_count <= r_instr_count;
      end
    end
  end

  // Moore output decode; only FETCH (mem_ready) and BRANCH (zero) look at inputs.
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_en      = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_pc_src     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = w_mem_ready;
        w_pc_en     = w_mem_ready;
      end
      S_DECODE: w_alu_src_b = 2'b11;
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        w_iord    = 1'b1;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_src    = 2'b01;
        w_pc_en     = zero;
      end
      S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        w_pc_src = 2'b10;
        w_pc_en  = 1'b1;
      end
      default: w_mem_req = 1'b0;
    endcase
  end

  // Strobes are suppressed while reset is held so nothing fires during reset.
  assign mem_req     = w_mem_req   & ~rst;
  assign mem_we      = w_mem_we    & ~rst;
  assign ir_write    = w_ir_write  & ~rst;
  assign pc_en       = w_pc_en     & ~rst;
  assign reg_write   = w_reg_write & ~rst;
  assign iord        = w_iord;
  assign reg_dst     = w_reg_dst;
  assign mem_to_reg  = w_mem_to_reg;
  assign alu_src_a   = w_alu_src_a;
  assign alu_src_b   = w_alu_src_b;
  assign alu_op      = w_alu_op;
  assign pc_src      = w_pc_src;
  assign state       = r_state;
  assign illegal     = r_illegal;
  assign instr_count = r_instr_count;

endmodule
